// File: rtl/gol_pkg.sv
// Shared types and constants for the 8x8 grid display path.
// row_word builds the 16-bit word shifted out for one display row.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int ROW_WORD_W = 16;

    // {one-hot row select, column bits of that row}; column 7 is the MSB of the low byte
    function automatic logic [ROW_WORD_W-1:0] row_word(input logic [ROWS*COLS-1:0] frame,
                                                       input logic [2:0]           row);
        logic [ROWS-1:0] sel;
        sel = 8'd1 << row;
        return {sel, frame[{row, 3'b000} +: COLS]};
    endfunction

endpackage

// File: rtl/grid_display_tx_phase_tick.sv
// Serial clock phase divider: tick marks the last clk cycle of each CLK_DIV-long phase.
// Counts only while enabled; the FSM clears it between phases of activity.
module phase_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign tick = en && (count_q == LAST);

    // Next divider count
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en) begin
            if (tick) begin
                count_d = 8'd0;
            end else begin
                count_d = count_q + 8'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Divider count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/grid_display_tx.sv
// Shifts a captured 8x8 frame out row by row to an LED shift-register chain.
// All outputs are registered copies of values derived from the next state.
module grid_display_tx
    import gol_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    input  logic        start,
    output logic        ready,
    output logic        ser_data,
    output logic        ser_clk,
    output logic        ser_latch,
    output logic        done
);

    tx_state_t       state_q, state_d;
    logic [63:0]     frame_q, frame_d;
    logic [3:0]      bit_q, bit_d;
    logic [2:0]      row_q, row_d;
    logic            half_q, half_d;
    logic            div_en_s, div_clr_s, tick_s;
    logic [ROW_WORD_W-1:0] word_s;
    logic            ready_q, ready_d;
    logic            ser_data_q, ser_data_d;
    logic            ser_clk_q, ser_clk_d;
    logic            ser_latch_q, ser_latch_d;
    logic            done_q, done_d;

    phase_tick #(.CLK_DIV(CLK_DIV)) u_phase_tick (
        .clk   (clk),
        .reset (reset),
        .en    (div_en_s),
        .clr   (div_clr_s),
        .tick  (tick_s)
    );

    // Next-state and counter control; half_q selects the low/high serial clock phase
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        row_d     = row_q;
        half_d    = half_q;
        div_en_s  = 1'b0;
        div_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                div_clr_s = 1'b1;
                bit_d     = 4'd0;
                row_d     = 3'd0;
                half_d    = 1'b0;
                if (start) begin
                    frame_d = grid;
                    state_d = SHIFT;
                end else begin
                    frame_d = frame_q;
                end
            end
            SHIFT: begin
                div_en_s = 1'b1;
                if (tick_s) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            bit_d   = 4'd0;
                            state_d = LATCH;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    half_d = half_q;
                end
            end
            LATCH: begin
                div_en_s = 1'b1;
                if (tick_s) begin
                    if (row_q == 3'(ROWS - 1)) begin
                        row_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 3'd1;
                        state_d = SHIFT;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            DONE: begin
                div_clr_s = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                div_clr_s = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, taken from the next state so they register in step
    always_comb begin
        word_s      = row_word(frame_d, row_d);
        ready_d     = (state_d == IDLE);
        ser_clk_d   = (state_d == SHIFT) && half_d;
        ser_latch_d = (state_d == LATCH);
        done_d      = (state_d == DONE);
        if (state_d == SHIFT) begin
            ser_data_d = word_s[4'd15 - bit_d];
        end else begin
            ser_data_d = 1'b0;
        end
    end

    // State, counters, frame and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_q     <= 64'd0;
            bit_q       <= 4'd0;
            row_q       <= 3'd0;
            half_q      <= 1'b0;
            ready_q     <= 1'b1;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            bit_q       <= bit_d;
            row_q       <= row_d;
            half_q      <= half_d;
            ready_q     <= ready_d;
            ser_data_q  <= ser_data_d;
            ser_clk_q   <= ser_clk_d;
            ser_latch_q <= ser_latch_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign ser_data  = ser_data_q;
    assign ser_clk   = ser_clk_q;
    assign ser_latch = ser_latch_q;
    assign done      = done_q;

endmodule

// File: doc/grid_display_tx.md
GRID_DISPLAY_TX -- requirements
Module: grid_display_tx

Interface
REQ-001 Parameter CLK_DIV, default 2, gives the clk cycles per serial clock phase; legal range is 1 to 255.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 grid  input  64  8x8 generation word; row r = grid[8r+7:8r]; bit 8r+7 is column 7.
REQ-005 start  input  1  frame request, sampled on the clk rising edge.
REQ-006 ready  output  1  high when idle; a start is accepted only while ready=1.
REQ-007 ser_data  output  1  serial data to the external LED shift-register chain.
REQ-008 ser_clk  output  1  serial shift clock; data is stable across each rising edge.
REQ-009 ser_latch  output  1  storage-latch pulse to the LED drivers after each row.
REQ-010 done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 The FSM SHALL have four states and no others.
- IDLE: ready=1; on start=1, capture grid and go to SHIFT.
- SHIFT: send the 16-bit row word.
- LATCH: pulse ser_latch.
- DONE: one cycle; done=1; go to IDLE.
REQ-012 In IDLE, start=1 SHALL capture grid into an internal frame register on that same edge, with ready=0 from the next cycle; later grid changes SHALL NOT affect the frame.
REQ-013 start while ready=0 SHALL be ignored and not queued.
REQ-014 Rows SHALL be sent in order 0 to 7; the row word is {row_sel[7:0], col[7:0]}, sent MSB first.
- row_sel is one-hot, with bit r set for row r.
- col[7:0] = captured row r.
REQ-015 Each bit SHALL occupy 2*CLK_DIV cycles.
- ser_clk is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
- ser_data changes only at bit start, while ser_clk is low.
REQ-016 After the 16th bit of a row, LATCH SHALL hold ser_latch=1 for CLK_DIV cycles, with ser_clk=0 and ser_data=0.
- After LATCH, go to SHIFT for the next row, or to DONE after row 7.
REQ-017 Outside SHIFT, ser_clk and ser_data SHALL be 0; outside LATCH, ser_latch SHALL be 0.
REQ-018 done SHALL assert exactly 264*CLK_DIV cycles after the accepting edge.
- ready SHALL return to 1 in the cycle after done.
- A start in that cycle SHALL begin a new frame.
REQ-019 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-020 Bit, row and divider counters SHALL be sized exactly: 4-bit bit index, 3-bit row index, 8-bit divider.
- Each counter wraps only under FSM control and never free-runs.

Reset
REQ-021 While reset=1, the block SHALL force state=IDLE, ready=1, ser_data=0, ser_clk=0, ser_latch=0, done=0 and clear all counters.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse and no further ser_clk edges.
REQ-023 The first start accepted after reset release SHALL produce a complete frame from row 0.

Structure
REQ-024 The following SHALL live in shared package gol_pkg:
- state enum tx_state_t {IDLE, SHIFT, LATCH, DONE};
- constants ROWS=8, COLS=8, ROW_WORD_W=16.
REQ-025 One sub-module, phase_tick, SHALL generate the CLK_DIV phase tick.
- Its enable and clear are driven by the FSM.
- It is the only divider in the design.

Verification
REQ-026 CLK_DIV=2, grid=64'h8000_0000_0000_0001, one start:
- row 0 word = 16'h0101;
- row 7 word = 16'h8080;
- all other rows = {one-hot row_sel, 8'h00};
- done at cycle 528;
- exactly 128 ser_clk rising edges;
- 8 latch pulses of 2 cycles each.
REQ-027 CLK_DIV=1, grid=all ones: every col byte = 8'hFF, ser_clk period = 2 cycles, done at cycle 264.
REQ-028 grid changes to 0 one cycle after acceptance: the transmitted frame still matches the captured value.
REQ-029 start held high continuously: back-to-back frames are sent; ready is high exactly one cycle between frames; no start is queued while busy.
REQ-030 reset asserted during row 3, bit 5: all outputs go to reset values within the same cycle.
- No done pulse occurs.
- After release, a new start sends row 0 first.
REQ-031 Checker on every frame:
- ser_data is stable whenever ser_clk=1;
- ser_latch and ser_clk are never both high.
